inst_decode: RTL and testbench
==============================

Name: inst_decode

Overview:
- Decode stage between the program counter/instruction ROM and the execute stage.
- Registers INST into an IF/ID register and reads operands from an internal 32x32 register file with writeback bypass.
- Resolves branches, driving BranchTrue/SrcB back into the PC counter, and launches ALU ops into a registered ID/EX interface.

Parameters:
- NREG, 32, register-file depth; r0 hardwired to zero.
- IMMW, 13, immediate field width; sign-extended to 32 bits.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- INST  in  32  instruction from the PC/ROM stage.
- wb_en  in  1  writeback strobe from execute.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback value.
- BranchTrue  out  1  combinational; taken branch resolved this cycle.
- SrcB  out  32  combinational; sign-extended branch offset (counter uses [4:0]).
- ex_valid  out  1  registered; ID/EX slot holds a live ALU op.
- ex_op  out  4  registered opcode.
- ex_a  out  32  registered operand A.
- ex_b  out  32  registered operand B.
- ex_rd  out  5  registered destination register.
- illegal  out  1  sticky flag; set when an undefined opcode is decoded.

Behaviour:
- Encoding (shared package):
  - op=INST[31:28], rd=[27:23], rs=[22:18], rt=[17:13], imm=sext([12:0]).
  - Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 BEQ, 7 BNE, 8 JMP; 9-15 undefined.
- IF/ID register: {id_inst, id_valid}. Each posedge loads INST with id_valid=1, except:
  - on RST: id_inst=0, id_valid=0;
  - when BranchTrue=1: flush, id_valid<=0, because INST holds the wrong-path fetch.
- Register file:
  - 2 async read ports on rs/rt, 1 sync write port; writes to r0 are ignored.
  - Reset clears all registers to 0.
- Bypass: if wb_en and wb_addr==rs (or rt) and the address is nonzero, the read returns wb_data in the same cycle. This applies to ALU operands and branch compare alike, so no stall logic is needed.
- Branch resolution (combinational, gated by id_valid):
  - BEQ: BranchTrue = (A==B).
  - BNE: BranchTrue = (A!=B).
  - JMP: BranchTrue = 1.
  - SrcB = imm whenever the op is a branch, else 0.
  - Target = (branch_addr+1+imm) mod 32, since the counter already points past the branch.
- ID/EX register:
  - Loads when id_valid and op is in 1..5.
  - ex_a = RS value. ex_b = RT value for ops 1-4, imm for op 5. ex_rd = rd. ex_valid = 1.
  - Otherwise (NOP, branch, undefined, bubble) ex_valid<=0; data fields hold their values.
- Undefined opcode with id_valid: treated as NOP and sets illegal<=1. Only RST clears it.
- Reset values: ex_valid=0, ex_op=0, ex_a=0, ex_b=0, ex_rd=0, illegal=0. BranchTrue=0 and SrcB=0 follow because id_valid=0.
- Reset mid-operation: all in-flight state is dropped. The first instruction after RST release reaches ID one cycle later.
- Simultaneous writeback to r0 plus a read of r0: the read returns 0.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams (OP_NOP..OP_JMP);
  - field bit-position constants;
  - the sign-extension function.
- Sub-module reg_file32: 32x32 storage, two async read ports, one write port, r0 forced to 0, write bypass inside.

Test Plan:
- Reset and first fetch: hold RST 2 cycles, release with INST=ADDI r1,r0,5 -> ex_valid=0 on the first edge after release; next edge ex_valid=1, ex_a=0, ex_b=5, ex_rd=1.
- Bypass: execute writes wb r1=5 while ID holds ADD r2,r1,r1 -> ex_a=5 and ex_b=5 in the same issue, with no stall.
- Taken BEQ r0,r0,imm=3 at address 4 -> BranchTrue=1 and SrcB=3 for one cycle; wrong-path INST flushed; ex_valid=0; counter next fetches address 8.
- Not-taken BNE r0,r0 -> BranchTrue=0 and no flush; the next instruction issues normally.
- Negative JMP imm=-5 at address 2 -> SrcB=0xFFFFFFFB; counter wraps to 30.
- Opcode 0xB -> ex_valid=0 and illegal=1 sticky across 10 cycles; RST clears it to 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared instruction encoding for the decode stage: opcodes, field positions,
// and immediate sign extension.
package decode_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_BEQ  = 4'd6,
        OP_BNE  = 4'd7,
        OP_JMP  = 4'd8
    } opcode_t;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 28;
    localparam int unsigned RD_MSB = 27;
    localparam int unsigned RD_LSB = 23;
    localparam int unsigned RS_MSB = 22;
    localparam int unsigned RS_LSB = 18;
    localparam int unsigned RT_MSB = 17;
    localparam int unsigned RT_LSB = 13;

    // Sign-extend the low w bits of inst to 32 bits.
    function automatic logic [31:0] sext_imm(input logic [31:0] inst, input int unsigned w);
        logic [31:0] shl;
        shl = inst << (32 - w);
        return 32'($signed(shl) >>> (32 - w));
    endfunction

endpackage

// File: rtl/reg_file32.sv
// General-purpose register file: two async read ports, one sync write port,
// r0 hardwired to zero, same-cycle write-to-read bypass.
module reg_file32 #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] ra_addr,
    output logic [31:0]   ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [31:0]   rb_data,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] mem [NREG];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i[AW-1:0]] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // r0 check comes first so a writeback aimed at r0 can never leak through.
    always_comb begin
        ra_data = mem[ra_addr];
        if (ra_addr == '0) begin
            ra_data = '0;
        end else if (we && (waddr == ra_addr)) begin
            ra_data = wdata;
        end
    end

    always_comb begin
        rb_data = mem[rb_addr];
        if (rb_addr == '0) begin
            rb_data = '0;
        end else if (we && (waddr == rb_addr)) begin
            rb_data = wdata;
        end
    end

endmodule

// File: rtl/inst_decode.sv
// Decode stage: IF/ID register, operand read with bypass, branch resolution
// back to the PC counter, and the registered ID/EX launch interface.
module inst_decode
    import decode_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned IMMW = 13
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INST,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        BranchTrue,
    output logic [31:0] SrcB,
    output logic        ex_valid,
    output logic [3:0]  ex_op,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [4:0]  ex_rd,
    output logic        illegal
);

    logic [31:0] id_inst;
    logic        id_valid;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        is_branch;
    logic        is_alu;
    logic        is_undef;

    assign op  = id_inst[OP_MSB:OP_LSB];
    assign rd  = id_inst[RD_MSB:RD_LSB];
    assign rs  = id_inst[RS_MSB:RS_LSB];
    assign rt  = id_inst[RT_MSB:RT_LSB];
    assign imm = sext_imm(id_inst, IMMW);

    reg_file32 #(
        .NREG (NREG),
        .AW   (5)
    ) u_rf (
        .CLK     (CLK),
        .RST     (RST),
        .ra_addr (rs),
        .ra_data (rs_val),
        .rb_addr (rt),
        .rb_data (rt_val),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    always_comb begin
        is_branch  = 1'b0;
        is_alu     = 1'b0;
        is_undef   = 1'b0;
        BranchTrue = 1'b0;
        case (op)
            OP_NOP:                                    ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:    is_alu = 1'b1;
            OP_BEQ: begin
                is_branch  = 1'b1;
                BranchTrue = (rs_val == rt_val);
            end
            OP_BNE: begin
                is_branch  = 1'b1;
                BranchTrue = (rs_val != rt_val);
            end
            OP_JMP: begin
                is_branch  = 1'b1;
                BranchTrue = 1'b1;
            end
            default:                                   is_undef = 1'b1;
        endcase
        BranchTrue = BranchTrue & id_valid;
        SrcB       = (id_valid && is_branch) ? imm : '0;
    end

    // A taken branch means INST is the wrong-path fetch, so it enters as a bubble.
    always_ff @(posedge CLK) begin
        if (RST) begin
            id_inst  <= '0;
            id_valid <= 1'b0;
        end else begin
            id_inst  <= INST;
            id_valid <= ~BranchTrue;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_valid <= 1'b0;
            ex_op    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rd    <= '0;
        end else if (id_valid && is_alu) begin
            ex_valid <= 1'b1;
            ex_op    <= op;
            ex_a     <= rs_val;
            ex_b     <= (op == OP_ADDI) ? imm : rt_val;
            ex_rd    <= rd;
        end else begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            illegal <= 1'b0;
        end else if (id_valid && is_undef) begin
            illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_decode.sv
// Directed bench for inst_decode: reset, bypass, branches, illegal opcode.
module tb_inst_decode;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] INST;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        BranchTrue;
    logic [31:0] SrcB;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_rd;
    logic        illegal;

    int tests  = 0;
    int failed = 0;
    logic [4:0] tgt;

    inst_decode #(.NREG(32), .IMMW(13)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .INST       (INST),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .BranchTrue (BranchTrue),
        .SrcB       (SrcB),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_rd      (ex_rd),
        .illegal    (illegal)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [12:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; INST = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_ex_op",    {28'b0, ex_op}, 32'd0);
        check("rst_ex_a",     ex_a, 32'd0);
        check("rst_ex_b",     ex_b, 32'd0);
        check("rst_ex_rd",    {27'b0, ex_rd}, 32'd0);
        check("rst_illegal",  {31'b0, illegal}, 32'd0);
        check("rst_branch",   {31'b0, BranchTrue}, 32'd0);
        check("rst_srcb",     SrcB, 32'd0);

        // first fetch after reset: ADDI r1,r0,5
        RST = 1'b0; INST = enc(4'd5, 5'd1, 5'd0, 5'd0, 13'd5);
        tick();
        check("first_ex_valid0", {31'b0, ex_valid}, 32'd0);
        INST = enc(4'd0, 5'd0, 5'd0, 5'd0, 13'd0);
        tick();
        check("addi_valid", {31'b0, ex_valid}, 32'd1);
        check("addi_op",    {28'b0, ex_op}, 32'd5);
        check("addi_a",     ex_a, 32'd0);
        check("addi_b",     ex_b, 32'd5);
        check("addi_rd",    {27'b0, ex_rd}, 32'd1);

        // ADD r2,r1,r1 in ID while execute writes back r1=5
        INST = enc(4'd1, 5'd2, 5'd1, 5'd1, 13'd0);
        tick();
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5; INST = '0;
        tick();
        wb_en = 1'b0;
        check("byp_valid", {31'b0, ex_valid}, 32'd1);
        check("byp_a",     ex_a, 32'd5);
        check("byp_b",     ex_b, 32'd5);
        check("byp_rd",    {27'b0, ex_rd}, 32'd2);

        // SUB r3,r1,r0 reads the now-stored r1
        INST = enc(4'd2, 5'd3, 5'd1, 5'd0, 13'd0);
        tick();
        INST = '0;
        tick();
        check("sub_op", {28'b0, ex_op}, 32'd2);
        check("sub_a",  ex_a, 32'd5);
        check("sub_b",  ex_b, 32'd0);

        // taken BEQ r0,r0,+3 at address 4
        INST = enc(4'd6, 5'd0, 5'd0, 5'd0, 13'd3);
        tick();
        check("beq_taken", {31'b0, BranchTrue}, 32'd1);
        check("beq_srcb",  SrcB, 32'd3);
        tgt = 5'd4 + 5'd1 + SrcB[4:0];
        check("beq_target", {27'b0, tgt}, 32'd8);
        check("beq_ex_valid", {31'b0, ex_valid}, 32'd0);
        INST = enc(4'd5, 5'd4, 5'd0, 5'd0, 13'd7);
        tick();
        check("flush_branch", {31'b0, BranchTrue}, 32'd0);
        check("flush_srcb",   SrcB, 32'd0);
        INST = '0;
        tick();
        check("flush_ex_valid", {31'b0, ex_valid}, 32'd0);

        // not-taken BNE r0,r0,+3
        INST = enc(4'd7, 5'd0, 5'd0, 5'd0, 13'd3);
        tick();
        check("bne_nt", {31'b0, BranchTrue}, 32'd0);
        check("bne_srcb", SrcB, 32'd3);
        INST = enc(4'd5, 5'd5, 5'd0, 5'd0, 13'd9);
        tick();
        INST = '0;
        tick();
        check("bne_next_valid", {31'b0, ex_valid}, 32'd1);
        check("bne_next_b",     ex_b, 32'd9);
        check("bne_next_rd",    {27'b0, ex_rd}, 32'd5);

        // BNE r1,r0 taken (5 != 0), BEQ r1,r0 not taken
        INST = enc(4'd7, 5'd0, 5'd1, 5'd0, 13'd1);
        tick();
        check("bne_taken", {31'b0, BranchTrue}, 32'd1);
        INST = '0;
        tick();
        INST = enc(4'd6, 5'd0, 5'd1, 5'd0, 13'd1);
        tick();
        check("beq_nt", {31'b0, BranchTrue}, 32'd0);

        // JMP -5 at address 2
        INST = enc(4'd8, 5'd0, 5'd0, 5'd0, 13'h1FFB);
        tick();
        check("jmp_taken", {31'b0, BranchTrue}, 32'd1);
        check("jmp_srcb",  SrcB, 32'hFFFFFFFB);
        tgt = 5'd2 + 5'd1 + SrcB[4:0];
        check("jmp_target", {27'b0, tgt}, 32'd30);
        INST = '0;
        tick();

        // writeback to r0 while ADD r6,r0,r0 reads r0
        INST = enc(4'd1, 5'd6, 5'd0, 5'd0, 13'd0);
        tick();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF; INST = '0;
        tick();
        wb_en = 1'b0;
        check("r0_valid", {31'b0, ex_valid}, 32'd1);
        check("r0_a", ex_a, 32'd0);
        check("r0_b", ex_b, 32'd0);

        // undefined opcode 0xB
        INST = 32'hB000_0000;
        tick();
        check("undef_pre", {31'b0, illegal}, 32'd0);
        INST = '0;
        tick();
        check("undef_ex_valid", {31'b0, ex_valid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("illegal_sticky", {31'b0, illegal}, 32'd1);
            tick();
        end

        // reset with ADDI in flight drops it and clears state
        INST = enc(4'd5, 5'd7, 5'd0, 5'd0, 13'd1);
        tick();
        RST = 1'b1; INST = '0;
        tick();
        check("mid_rst_illegal", {31'b0, illegal}, 32'd0);
        check("mid_rst_valid",   {31'b0, ex_valid}, 32'd0);
        check("mid_rst_b",       ex_b, 32'd0);
        RST = 1'b0; INST = enc(4'd1, 5'd8, 5'd1, 5'd0, 13'd0);
        tick();
        check("post_rst_valid0", {31'b0, ex_valid}, 32'd0);
        INST = '0;
        tick();
        check("post_rst_valid1", {31'b0, ex_valid}, 32'd1);
        check("post_rst_r1",     ex_a, 32'd0);
        check("post_rst_rd",     {27'b0, ex_rd}, 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
